data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//   Shares one byte-wide data memory between two 32-bit word requesters.
//   Port 0 is the CPU load/store path; port 1 is the debug/loader path.
//   Each granted word access is sequenced as four byte transfers at addr+0..addr+3.
//   Byte order is big-endian: addr+0 carries bits [31:24].
//   Sits between the core datapath and the memory array; the array reads combinationally and writes on posedge.
// PARAMETERS
//   ADDR_W   32   address width (byte address)
//   FAIR     1    1 = round-robin between ports, 0 = fixed priority to port 0
// PORTS
//   clk        in   1       system clock, all state on posedge
//   reset      in   1       synchronous, active-high
//   r0_req     in   1       port 0 request; held high until r0_ack
//   r0_we      in   1       port 0: 1 = write, 0 = read
//   r0_addr    in   ADDR_W  port 0 byte address; bits [1:0] ignored (forced 0)
//   r0_wdata   in   32      port 0 write data
//   r0_ack     out  1       port 0 one-cycle completion pulse
//   r0_rdata   out  32      port 0 read data, valid while r0_ack=1
//   r1_*       —    —       port 1 signals, identical to r0_*
//   mem_addr   out  ADDR_W  byte address to memory
//   mem_wdata  out  8       byte write data
//   mem_we     out  1       byte write strobe, sampled by memory at posedge
//   mem_re     out  1       byte read enable
//   mem_rdata  in   8       byte read data, combinational from mem_addr
//   busy       out  1       high in ACCESS and DONE
// BEHAVIOUR
//   Reset values:
//     all outputs are 0; state = IDLE; byte counter = 0.
//     last_grant = 1, so port 0 wins the first tie.
//   FSM states: IDLE -> ACCESS -> DONE -> IDLE.
//   IDLE
//     If any req is high, grant and latch that port's we/addr/wdata, then go to ACCESS with cnt = 0.
//     Tie with FAIR=1: grant the port that is not last_grant.
//     Tie with FAIR=0: grant port 0.
//     No req: stay in IDLE; all mem_* outputs are 0.
//   ACCESS, cnt = 0..3, one byte per cycle:
//     mem_addr = {addr[ADDR_W-1:2], 2'b00} + cnt.
//     Write: mem_we = 1, mem_re = 0, mem_wdata = wdata byte (3 - cnt).
//     Read: mem_re = 1, mem_we = 0; mem_rdata is captured at posedge into rdata byte (3 - cnt).
//     When cnt = 3, go to DONE.
//   DONE
//     The granted port sees ack = 1 for exactly this cycle; for reads, rdata holds the assembled word.
//     last_grant is updated to the granted port; the next state is IDLE.
//     mem_we = 0 and mem_re = 0.
//   Latency:
//     req sampled in IDLE at cycle T; bytes are transferred in T+1..T+4; ack is high in T+5.
//     Back-to-back requests start a new grant at T+6 (one IDLE cycle between transactions).
//   Data hold and commitment:
//     rN_rdata holds its value until the next read completion on that port.
//     A write acks with rdata unchanged.
//     Once granted, a transaction completes even if req drops mid-way; ack still pulses.
//     req is not sampled during ACCESS or DONE.
//   Address wrap: the addr+cnt sum is taken modulo 2^ADDR_W.
//   The ungranted port never sees ack, and its req is not lost while waiting.
//   Reset mid-operation: at the next posedge the FSM goes to IDLE; no further mem_we is asserted.
//     Bytes already written stay written; no ack is issued; rdata outputs are cleared to 0.
// TESTING
//   1. r0 write, addr 0x10, data 0xA1B2C3D4
//      -> mem_we at 0x10..0x13 with bytes A1, B2, C3, D4; r0_ack at T+5.
//   2. r0 read, addr 0x10, after test 1 -> r0_rdata = 0xA1B2C3D4 when r0_ack = 1.
//   3. r0 and r1 both request continuously, FAIR = 1
//      -> grants alternate 0, 1, 0, 1, with acks 6 cycles apart.
//   4. r1 write, addr 0x13 -> low bits are ignored; bytes land at 0x10..0x13.
//   5. r0 write, addr 0xFFFFFFFC -> bytes land at 0xFFFFFFFC..0xFFFFFFFF; the counter does not overflow into the grant.
//   6. reset asserted during ACCESS with cnt = 2
//      -> the next cycle is IDLE, mem_we = 0, no ack; a fresh r0 request then completes normally.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares one byte-wide data memory between two 32-bit word requesters.
//   Port 0 is the CPU load/store path, port 1 the debug/loader path. A
//   granted word access is carried out as four byte transfers at
//   addr+0..addr+3, big-endian (addr+0 carries bits [31:24]). The memory
//   reads combinationally and writes on the rising clock edge.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   rN_req/we/addr/wdata  word request from port N (req held until ack)
//   rN_ack              one-cycle completion pulse for port N
//   rN_rdata            last word read by port N, held until its next read
//   mem_addr/wdata/we/re  byte interface to the memory
//   mem_rdata           combinational byte read data
//   busy                high while a word transaction is in flight
module data_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter bit FAIR   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [31:0]       r0_wdata,
    output logic              r0_ack,
    output logic [31:0]       r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [31:0]       r1_wdata,
    output logic              r1_ack,
    output logic [31:0]       r1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                gnt_q, gnt_d;
    logic                last_q, last_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [23:0]         rbuf_q, rbuf_d;
    logic [1:0][31:0]    rdata_q, rdata_d;

    // Port-indexed views of the two request interfaces.
    logic [1:0]              req_v;
    logic [1:0]              we_v;
    logic [1:0][ADDR_W-1:0]  addr_v;
    logic [1:0][31:0]        wdata_v;
    logic                    sel;

    assign req_v   = {r1_req, r0_req};
    assign we_v    = {r1_we, r0_we};
    assign addr_v  = {r1_addr, r0_addr};
    assign wdata_v = {r1_wdata, r0_wdata};

    // Arbitration: a lone requester wins; on a tie, round-robin picks the
    // port that did not win last time, fixed priority picks port 0.
    always_comb begin
        sel = 1'b0;
        if (req_v == 2'b10) begin
            sel = 1'b1;
        end else if (req_v == 2'b11) begin
            sel = FAIR ? ~last_q : 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rbuf_d    = rbuf_q;
        rdata_d   = rdata_q;
        mem_addr  = '0;
        mem_wdata = 8'h00;
        mem_we    = 1'b0;
        mem_re    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (|req_v) begin
                    state_d = S_ACCESS;
                    cnt_d   = 2'd0;
                    gnt_d   = sel;
                    we_d    = we_v[sel];
                    // Word-align here so the byte address below is a plain add.
                    addr_d  = addr_v[sel] & ~ADDR_W'(3);
                    wdata_d = wdata_v[sel];
                end
            end
            S_ACCESS: begin
                // Sum wraps naturally at 2^ADDR_W.
                mem_addr = addr_q + ADDR_W'(cnt_q);
                if (we_q) begin
                    mem_we    = 1'b1;
                    // ~cnt_q == 3 - cnt_q: byte 3 (MSB) goes out first.
                    mem_wdata = wdata_q[{~cnt_q, 3'b000} +: 8];
                end else begin
                    mem_re = 1'b1;
                    // Bytes arrive MSB first, so shifting left assembles the
                    // word big-endian; the last byte lands straight in rdata.
                    if (cnt_q == 2'd3) begin
                        rdata_d[gnt_q] = {rbuf_q, mem_rdata};
                    end else begin
                        rbuf_d = {rbuf_q[15:0], mem_rdata};
                    end
                end
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                last_d  = gnt_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rbuf_q  <= 24'h0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rbuf_q  <= rbuf_d;
            rdata_q <= rdata_d;
        end
    end

    assign r0_ack   = (state_q == S_DONE) && (gnt_q == 1'b0);
    assign r1_ack   = (state_q == S_DONE) && (gnt_q == 1'b1);
    assign r0_rdata = rdata_q[0];
    assign r1_rdata = rdata_q[1];
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  rq, rwe;
    logic [31:0] raddr [2];
    logic [31:0] rwd   [2];
    logic        r0_ack, r1_ack;
    logic [31:0] r0_rdata, r1_rdata;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_we, mem_re, busy;

    always #5 clk = ~clk;

    data_mem_arbiter #(.ADDR_W(32), .FAIR(1'b1)) dut (
        .clk(clk), .reset(reset),
        .r0_req(rq[0]), .r0_we(rwe[0]), .r0_addr(raddr[0]), .r0_wdata(rwd[0]),
        .r0_ack(r0_ack), .r0_rdata(r0_rdata),
        .r1_req(rq[1]), .r1_we(rwe[1]), .r1_addr(raddr[1]), .r1_wdata(rwd[1]),
        .r1_ack(r1_ack), .r1_rdata(r1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_rdata(mem_rdata), .busy(busy)
    );

    // Byte memory model, indexed by the low address byte; every access is logged.
    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [7:0]  data;
    } acc_t;

    logic [7:0] mem [256];
    acc_t       log_q [$];

    assign mem_rdata = mem[mem_addr[7:0]];

    always @(posedge clk) begin
        if (mem_we || mem_re) begin
            log_q.push_back('{we: mem_we, addr: mem_addr, data: (mem_we ? mem_wdata : mem_rdata)});
        end
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] rd_exp [2];
    bit          tb_last;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] rdata_of(input bit p);
        return p ? r1_rdata : r0_rdata;
    endfunction

    function automatic logic ack_of(input bit p);
        return p ? r1_ack : r0_ack;
    endfunction

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] base;
        logic [31:0] exp_rd;
        bit          drop;
    } vec_t;

    // One word transaction, checked for latency, byte sequence and rdata.
    task automatic run_txn(input vec_t v);
        int         ack_k;
        bit         other_ack;
        logic [31:0] word;
        log_q.delete();
        ack_k     = 0;
        other_ack = 1'b0;
        @(negedge clk);
        rq[v.port]    = 1'b1;
        rwe[v.port]   = v.we;
        raddr[v.port] = v.addr;
        rwd[v.port]   = v.wdata;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (v.drop && k == 1) rq[v.port] = 1'b0;
            if (ack_of(!v.port)) other_ack = 1'b1;
            if (ack_of(v.port)) begin
                ack_k = k;
                if (!v.we) rd_exp[v.port] = v.exp_rd;
                chk("rdata_at_ack", rdata_of(v.port), rd_exp[v.port]);
                rq[v.port] = 1'b0;
                break;
            end
        end
        chk("ack_latency", 32'(ack_k), 32'd5);
        chk("no_other_ack", {31'b0, other_ack}, 32'd0);
        chk("byte_count", 32'(log_q.size()), 32'd4);
        word = v.we ? v.wdata : v.exp_rd;
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            chk("byte_addr", log_q[i].addr, v.base + 32'(i));
            chk("byte_dir", {31'b0, log_q[i].we}, {31'b0, v.we});
            chk("byte_data", {24'b0, log_q[i].data}, {24'b0, word[31-8*i -: 8]});
        end
        tb_last = v.port;
    endtask

    vec_t vecs [9];

    initial begin
        int   acks, prev_k;
        bit   exp_p, any_we, any_ack;

        vecs[0] = '{port: 0, we: 1, addr: 32'h10,       wdata: 32'hA1B2C3D4, base: 32'h10,       exp_rd: 32'h0,        drop: 0};
        vecs[1] = '{port: 0, we: 0, addr: 32'h10,       wdata: 32'h0,        base: 32'h10,       exp_rd: 32'hA1B2C3D4, drop: 0};
        vecs[2] = '{port: 1, we: 1, addr: 32'h13,       wdata: 32'h11223344, base: 32'h10,       exp_rd: 32'h0,        drop: 0};
        vecs[3] = '{port: 1, we: 0, addr: 32'h12,       wdata: 32'h0,        base: 32'h10,       exp_rd: 32'h11223344, drop: 1};
        vecs[4] = '{port: 0, we: 0, addr: 32'h11,       wdata: 32'h0,        base: 32'h10,       exp_rd: 32'h11223344, drop: 0};
        vecs[5] = '{port: 0, we: 1, addr: 32'hFFFFFFFC, wdata: 32'hCAFEBABE, base: 32'hFFFFFFFC, exp_rd: 32'h0,        drop: 0};
        vecs[6] = '{port: 1, we: 0, addr: 32'hFFFFFFFE, wdata: 32'h0,        base: 32'hFFFFFFFC, exp_rd: 32'hCAFEBABE, drop: 0};
        vecs[7] = '{port: 0, we: 1, addr: 32'h20,       wdata: 32'hDEADBEEF, base: 32'h20,       exp_rd: 32'h0,        drop: 0};
        vecs[8] = '{port: 1, we: 0, addr: 32'h22,       wdata: 32'h0,        base: 32'h20,       exp_rd: 32'hDEADBEEF, drop: 1};

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rq = 2'b00; rwe = 2'b00;
        raddr[0] = 32'h0; raddr[1] = 32'h0; rwd[0] = 32'h0; rwd[1] = 32'h0;
        rd_exp[0] = 32'h0; rd_exp[1] = 32'h0;
        tb_last = 1'b1;

        // Reset state
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_acks", {30'b0, r1_ack, r0_ack}, 32'd0);
        chk("rst_r0_rdata", r0_rdata, 32'h0);
        chk("rst_r1_rdata", r1_rdata, 32'h0);
        chk("rst_mem_ctl", {29'b0, busy, mem_we, mem_re}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", {24'b0, mem_wdata}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) run_txn(vecs[i]);

        // Both ports request continuously: grants alternate, acks 6 cycles apart.
        log_q.delete();
        @(negedge clk);
        rwe = 2'b11;
        raddr[0] = 32'h30; rwd[0] = 32'h01020304;
        raddr[1] = 32'h34; rwd[1] = 32'h05060708;
        rq = 2'b11;
        exp_p  = !tb_last;
        acks   = 0;
        prev_k = 0;
        for (int k = 1; k <= 40 && acks < 4; k++) begin
            @(negedge clk);
            if (r0_ack && r1_ack) chk("rr_double_ack", 32'd1, 32'd0);
            if (r0_ack || r1_ack) begin
                chk("rr_port", {31'b0, r1_ack}, {31'b0, exp_p});
                if (acks > 0) chk("rr_gap", 32'(k - prev_k), 32'd6);
                prev_k = k;
                exp_p  = !exp_p;
                acks++;
                if (acks == 4) rq = 2'b00;
            end
        end
        chk("rr_ack_count", 32'(acks), 32'd4);
        chk("rr_mem0", {mem[8'h30], mem[8'h31], mem[8'h32], mem[8'h33]}, 32'h01020304);
        chk("rr_mem1", {mem[8'h34], mem[8'h35], mem[8'h36], mem[8'h37]}, 32'h05060708);
        tb_last = !exp_p;

        // Reset during ACCESS with cnt = 2.
        @(negedge clk);
        log_q.delete();
        rwe[0] = 1'b1; raddr[0] = 32'h40; rwd[0] = 32'h55667788; rq[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        rq[0] = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_we", {31'b0, mem_we}, 32'd0);
        chk("mid_rst_ack", {30'b0, r1_ack, r0_ack}, 32'd0);
        chk("mid_rst_r0_rdata", r0_rdata, 32'h0);
        chk("mid_rst_r1_rdata", r1_rdata, 32'h0);
        reset = 1'b0;
        any_we = 1'b0; any_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            any_we  |= mem_we;
            any_ack |= r0_ack | r1_ack;
        end
        chk("post_rst_we", {31'b0, any_we}, 32'd0);
        chk("post_rst_ack", {31'b0, any_ack}, 32'd0);
        chk("rst_bytes_written", 32'(log_q.size()), 32'd3);
        chk("rst_mem", {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]}, 32'h55667700);
        rd_exp[0] = 32'h0; rd_exp[1] = 32'h0;
        tb_last = 1'b1;

        run_txn('{port: 0, we: 1, addr: 32'h40, wdata: 32'h99AABBCC, base: 32'h40, exp_rd: 32'h0,        drop: 0});
        run_txn('{port: 0, we: 0, addr: 32'h40, wdata: 32'h0,        base: 32'h40, exp_rd: 32'h99AABBCC, drop: 0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
